osd_cdm_spr_bridge: RTL and testbench
=====================================

OSD_CDM_SPR_BRIDGE -- requirements
Module: osd_cdm_spr_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: max cycles spr_req waits for spr_ack before an error is returned; range 1..65535.
REQ-002 Parameter REQUIRE_STALL, default 1: when 1, SPR accesses are refused with error unless the CPU is stalled.
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 du_stall_i  input  1  stall request from the CDM.
REQ-006 du_stall_o  output  1  CPU halted at a breakpoint (sticky), to the CDM.
REQ-007 du_stb_i  input  1  access strobe from the CDM, held high until du_ack_o.
REQ-008 du_ack_o  output  1  one-cycle access completion.
REQ-009 du_err_o  output  1  qualifies du_ack_o as failed (refused or timed out).
REQ-010 du_adr_i  input  16  SPR address.
REQ-011 du_we_i  input  1  1 = write, 0 = read.
REQ-012 du_dat_i  input  32  write data.
REQ-013 du_dat_o  output  32  read data, valid with du_ack_o.
REQ-014 cpu_stall  output  1  stall to the CPU pipeline.
REQ-015 cpu_bp  input  1  CPU breakpoint hit, level.
REQ-016 spr_req / spr_we  output  1 / 1  CPU SPR-port request and direction.
REQ-017 spr_addr / spr_wdata  output  16 / 32  SPR-port address and write data.
REQ-018 spr_ack / spr_rdata  input  1 / 32  SPR-port completion and read data.

Function
REQ-019 Stall tracking: bp_latched sets in the cycle after cpu_bp is sampled high, and clears in the cycle after a 1->0 transition of du_stall_i is sampled; if set and clear coincide, set wins.
REQ-020 cpu_stall = du_stall_i OR bp_latched (combinational); du_stall_o = bp_latched (registered).
REQ-021 FSM states: IDLE, REQ, DONE, ERR, HOLD.
REQ-022 IDLE: on du_stb_i=1, capture du_adr_i, du_we_i and du_dat_i into spr_addr, spr_we and spr_wdata, and clear the timeout counter; go to ERR if REQUIRE_STALL=1 and cpu_stall=0, otherwise go to REQ.
REQ-023 REQ: spr_req=1, with spr_addr, spr_we and spr_wdata held stable; the counter increments every cycle.
REQ-024 REQ: spr_ack=1 captures spr_rdata (reads only) and moves to DONE; counter reaching TIMEOUT_CYCLES without ack moves to ERR.
REQ-025 If spr_ack and timeout occur in the same cycle, ack wins and the FSM goes to DONE.
REQ-026 DONE: du_ack_o=1 and du_err_o=0 for exactly one cycle; du_dat_o = captured read data, or 0 for writes; then go to HOLD.
REQ-027 ERR: du_ack_o=1, du_err_o=1 and du_dat_o=0 for exactly one cycle; spr_req=0; then go to HOLD.
REQ-028 HOLD: wait for du_stb_i=0, then return to IDLE; no new access starts while du_stb_i stays high.
REQ-029 spr_ack outside REQ is ignored and produces no du_ack_o.
REQ-030 Latency: du_stb_i sampled at edge 0 gives spr_req=1 after edge 1; spr_ack sampled at edge N gives du_ack_o=1 after edge N+1.
REQ-031 du_dat_o holds its value outside du_ack_o cycles.
REQ-032 The counter is 16 bits and saturates at TIMEOUT_CYCLES; it never wraps.
REQ-033 A stall change during an access does not abort the access.

Reset
REQ-034 With rst sampled high, after that edge: state=IDLE, bp_latched=0, counter=0, spr_req=0, spr_we=0, spr_addr=0, spr_wdata=0, du_ack_o=0, du_err_o=0, du_dat_o=0, du_stall_o=0.
REQ-035 Reset mid-access abandons the transaction; spr_req is low in the first post-reset cycle, and no du_ack_o is produced for the abandoned access.

Verification
REQ-036 Stalled read: du_stall_i=1, stb adr=0x0010 we=0, spr_ack 3 cycles later with rdata=0xDEADBEEF -> one-cycle du_ack_o, du_err_o=0, du_dat_o=0xDEADBEEF.
REQ-037 Write: stalled, stb adr=0x2001 we=1 dat=0x12345678 -> spr_req with spr_we=1, spr_addr=0x2001, spr_wdata=0x12345678; ack -> du_ack_o with du_dat_o=0.
REQ-038 Unstalled access, REQUIRE_STALL=1: du_stall_i=0, bp idle, stb -> no spr_req; du_ack_o=1 and du_err_o=1 two edges after stb.
REQ-039 Timeout, TIMEOUT_CYCLES=4: spr_ack never asserted -> spr_req high for exactly 4 cycles, then du_ack_o=1 with du_err_o=1.
REQ-040 Breakpoint: cpu_bp pulse of 1 cycle -> cpu_stall and du_stall_o stay high; du_stall_i 1->0 -> both low the next cycle.
REQ-041 Reset mid-REQ: rst asserted 2 cycles into REQ -> spr_req=0 and du_ack_o never asserted; the next access completes normally.

Source files
------------

// File: rtl/osd_cdm_spr_bridge_if.sv
// Debug-unit access bus between the CDM and the SPR bridge, plus the CDM stall pair.
// master = CDM side (drives strobe/address/data/stall request); slave = bridge side.
// Handshake: du_stb_i is held high until a one-cycle du_ack_o, qualified by du_err_o.
interface osd_cdm_spr_bridge_if;
    logic        du_stall_i;
    logic        du_stall_o;
    logic        du_stb_i;
    logic        du_ack_o;
    logic        du_err_o;
    logic [15:0] du_adr_i;
    logic        du_we_i;
    logic [31:0] du_dat_i;
    logic [31:0] du_dat_o;

    modport master (
        output du_stall_i, du_stb_i, du_adr_i, du_we_i, du_dat_i,
        input  du_stall_o, du_ack_o, du_err_o, du_dat_o
    );

    modport slave (
        input  du_stall_i, du_stb_i, du_adr_i, du_we_i, du_dat_i,
        output du_stall_o, du_ack_o, du_err_o, du_dat_o
    );
endinterface

// File: rtl/osd_cdm_spr_bridge.sv
// Bridges CDM debug accesses onto the CPU SPR port and tracks breakpoint stall state.
// Latency: strobe -> spr_req after 2 edges; spr_ack -> du_ack_o after 2 edges.
// Backpressure: the CDM holds du_stb_i until du_ack_o; the SPR side stalls via spr_ack,
// bounded by TIMEOUT_CYCLES, after which the access completes with du_err_o.
// Ports: clk, rst (sync, active-high); du (CDM bus, slave modport);
//        cpu_stall / cpu_bp (CPU pipeline); spr_* (CPU SPR request port).
module osd_cdm_spr_bridge #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter bit REQUIRE_STALL  = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    osd_cdm_spr_bridge_if.slave         du,
    output logic                        cpu_stall,
    input  logic                        cpu_bp,
    output logic                        spr_req,
    output logic                        spr_we,
    output logic [15:0]                 spr_addr,
    output logic [31:0]                 spr_wdata,
    input  logic                        spr_ack,
    input  logic [31:0]                 spr_rdata
);

    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_DONE,
        S_ERR,
        S_HOLD
    } state_t;

    state_t      state;
    logic [15:0] tmo_cnt;
    logic [31:0] rdata_q;
    logic        bp_latched;
    logic        stall_q;

    assign cpu_stall     = du.du_stall_i | bp_latched;
    assign du.du_stall_o = bp_latched;

    // Breakpoint latch: set by cpu_bp, cleared by a falling edge of the CDM stall
    // request. Set has priority so a breakpoint landing on the release is not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            bp_latched <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            stall_q <= du.du_stall_i;
            if (cpu_bp)
                bp_latched <= 1'b1;
            else if (stall_q && !du.du_stall_i)
                bp_latched <= 1'b0;
        end
    end

    // Access FSM. All outputs are registered, so each state's outputs appear in the
    // cycle after the state is entered: spr_req rises one cycle into REQ and
    // du_ack_o is visible during the first HOLD cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            tmo_cnt     <= '0;
            rdata_q     <= '0;
            spr_req     <= 1'b0;
            spr_we      <= 1'b0;
            spr_addr    <= '0;
            spr_wdata   <= '0;
            du.du_ack_o <= 1'b0;
            du.du_err_o <= 1'b0;
            du.du_dat_o <= '0;
        end else begin
            du.du_ack_o <= 1'b0;
            du.du_err_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    spr_req <= 1'b0;
                    if (du.du_stb_i) begin
                        spr_addr  <= du.du_adr_i;
                        spr_we    <= du.du_we_i;
                        spr_wdata <= du.du_dat_i;
                        tmo_cnt   <= '0;
                        if (REQUIRE_STALL && !cpu_stall)
                            state <= S_ERR;
                        else
                            state <= S_REQ;
                    end
                end

                S_REQ: begin
                    // Counter saturates at the limit so it can never wrap back.
                    if (tmo_cnt != TIMEOUT_LIM)
                        tmo_cnt <= tmo_cnt + 16'd1;
                    // Ack is only meaningful once spr_req is actually driven; it is
                    // checked before the timeout so a coincident ack still succeeds.
                    if (spr_req && spr_ack) begin
                        spr_req <= 1'b0;
                        rdata_q <= spr_we ? 32'h0 : spr_rdata;
                        state   <= S_DONE;
                    end else if (tmo_cnt == TIMEOUT_LIM) begin
                        spr_req <= 1'b0;
                        state   <= S_ERR;
                    end else begin
                        spr_req <= 1'b1;
                    end
                end

                S_DONE: begin
                    du.du_ack_o <= 1'b1;
                    du.du_dat_o <= rdata_q;
                    state       <= S_HOLD;
                end

                S_ERR: begin
                    du.du_ack_o <= 1'b1;
                    du.du_err_o <= 1'b1;
                    du.du_dat_o <= '0;
                    state       <= S_HOLD;
                end

                S_HOLD: begin
                    // Wait for the CDM to drop its strobe so one strobe = one access.
                    if (!du.du_stb_i)
                        state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_osd_cdm_spr_bridge.sv
// Directed bench for osd_cdm_spr_bridge with TIMEOUT_CYCLES=4, REQUIRE_STALL=1.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_osd_cdm_spr_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_stall;
    logic        cpu_bp;
    logic        spr_req;
    logic        spr_we;
    logic [15:0] spr_addr;
    logic [31:0] spr_wdata;
    logic        spr_ack;
    logic [31:0] spr_rdata;

    int n_cmp = 0;
    int n_err = 0;

    osd_cdm_spr_bridge_if du_if ();

    osd_cdm_spr_bridge #(
        .TIMEOUT_CYCLES(4),
        .REQUIRE_STALL (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .du        (du_if),
        .cpu_stall (cpu_stall),
        .cpu_bp    (cpu_bp),
        .spr_req   (spr_req),
        .spr_we    (spr_we),
        .spr_addr  (spr_addr),
        .spr_wdata (spr_wdata),
        .spr_ack   (spr_ack),
        .spr_rdata (spr_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hi_cnt;
        int acks;
        logic seen;

        rst              = 1'b1;
        cpu_bp           = 1'b0;
        spr_ack          = 1'b0;
        spr_rdata        = 32'h0;
        du_if.du_stall_i = 1'b0;
        du_if.du_stb_i   = 1'b0;
        du_if.du_adr_i   = 16'h0;
        du_if.du_we_i    = 1'b0;
        du_if.du_dat_i   = 32'h0;
        tick();
        tick();

        // Reset state
        check("rst_spr_req",   spr_req,          0);
        check("rst_spr_we",    spr_we,           0);
        check("rst_spr_addr",  spr_addr,         0);
        check("rst_spr_wdata", spr_wdata,        0);
        check("rst_ack",       du_if.du_ack_o,   0);
        check("rst_err",       du_if.du_err_o,   0);
        check("rst_dat",       du_if.du_dat_o,   0);
        check("rst_stall_o",   du_if.du_stall_o, 0);
        check("rst_cpu_stall", cpu_stall,        0);
        rst = 1'b0;
        tick();

        // Stalled read, ack three cycles after spr_req
        du_if.du_stall_i = 1'b1;
        du_if.du_stb_i   = 1'b1;
        du_if.du_adr_i   = 16'h0010;
        du_if.du_we_i    = 1'b0;
        du_if.du_dat_i   = 32'hFFFF_FFFF;
        tick();
        check("rd_req_latency", spr_req, 0);
        tick();
        check("rd_req",  spr_req,  1);
        check("rd_addr", spr_addr, 32'h0010);
        check("rd_we",   spr_we,   0);
        tick();
        tick();
        spr_ack   = 1'b1;
        spr_rdata = 32'hDEAD_BEEF;
        tick();
        spr_ack   = 1'b0;
        spr_rdata = 32'h0;
        check("rd_ack_latency", du_if.du_ack_o, 0);
        tick();
        check("rd_ack", du_if.du_ack_o, 1);
        check("rd_err", du_if.du_err_o, 0);
        check("rd_dat", du_if.du_dat_o, 32'hDEAD_BEEF);
        du_if.du_stb_i = 1'b0;
        tick();
        check("rd_ack_once",  du_if.du_ack_o, 0);
        check("rd_dat_holds", du_if.du_dat_o, 32'hDEAD_BEEF);

        // Stalled write
        du_if.du_stb_i = 1'b1;
        du_if.du_adr_i = 16'h2001;
        du_if.du_we_i  = 1'b1;
        du_if.du_dat_i = 32'h1234_5678;
        tick();
        tick();
        check("wr_req",   spr_req,   1);
        check("wr_we",    spr_we,    1);
        check("wr_addr",  spr_addr,  32'h2001);
        check("wr_wdata", spr_wdata, 32'h1234_5678);
        spr_ack   = 1'b1;
        spr_rdata = 32'hCAFE_F00D;
        tick();
        spr_ack = 1'b0;
        tick();
        check("wr_ack", du_if.du_ack_o, 1);
        check("wr_err", du_if.du_err_o, 0);
        check("wr_dat", du_if.du_dat_o, 0);
        du_if.du_stb_i = 1'b0;
        tick();

        // Stray spr_ack while idle
        spr_ack = 1'b1;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (du_if.du_ack_o) acks++;
        end
        spr_ack = 1'b0;
        check("stray_ack", acks, 0);

        // Unstalled access is refused
        du_if.du_stall_i = 1'b0;
        tick();
        du_if.du_stb_i = 1'b1;
        du_if.du_adr_i = 16'h0005;
        du_if.du_we_i  = 1'b0;
        tick();
        check("unst_no_ack_yet", du_if.du_ack_o, 0);
        tick();
        check("unst_ack", du_if.du_ack_o, 1);
        check("unst_err", du_if.du_err_o, 1);
        check("unst_dat", du_if.du_dat_o, 0);
        check("unst_req", spr_req,        0);
        acks = 0;
        hi_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (du_if.du_ack_o) acks++;
            if (spr_req) hi_cnt++;
        end
        check("hold_no_ack", acks,   0);
        check("hold_no_req", hi_cnt, 0);
        du_if.du_stb_i = 1'b0;
        tick();

        // Timeout after 4 cycles of spr_req
        du_if.du_stall_i = 1'b1;
        du_if.du_stb_i   = 1'b1;
        du_if.du_adr_i   = 16'h0077;
        tick();
        hi_cnt = 0;
        seen   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (du_if.du_ack_o) begin
                seen = 1'b1;
                break;
            end
            if (spr_req) hi_cnt++;
        end
        check("to_ack_seen", seen,           1);
        check("to_req_cnt",  hi_cnt,         4);
        check("to_err",      du_if.du_err_o, 1);
        check("to_dat",      du_if.du_dat_o, 0);
        du_if.du_stb_i = 1'b0;
        tick();

        // Ack on the same cycle the counter reaches the limit: ack wins
        du_if.du_stb_i = 1'b1;
        du_if.du_adr_i = 16'h0088;
        du_if.du_we_i  = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) tick();
        check("race_req", spr_req, 1);
        spr_ack   = 1'b1;
        spr_rdata = 32'h0BAD_F00D;
        tick();
        spr_ack = 1'b0;
        tick();
        check("race_ack", du_if.du_ack_o, 1);
        check("race_err", du_if.du_err_o, 0);
        check("race_dat", du_if.du_dat_o, 32'h0BAD_F00D);
        du_if.du_stb_i   = 1'b0;
        du_if.du_stall_i = 1'b0;
        tick();
        tick();

        // Breakpoint latch
        cpu_bp = 1'b1;
        tick();
        cpu_bp = 1'b0;
        check("bp_stall_o",   du_if.du_stall_o, 1);
        check("bp_cpu_stall", cpu_stall,        1);
        tick();
        tick();
        check("bp_sticky", du_if.du_stall_o, 1);
        du_if.du_stall_i = 1'b1;
        tick();
        du_if.du_stall_i = 1'b0;
        #1;
        check("bp_stall_before_edge", cpu_stall, 1);
        tick();
        check("bp_clr_stall_o",   du_if.du_stall_o, 0);
        check("bp_clr_cpu_stall", cpu_stall,        0);

        // Breakpoint coinciding with stall release: set wins
        du_if.du_stall_i = 1'b1;
        tick();
        du_if.du_stall_i = 1'b0;
        cpu_bp           = 1'b1;
        tick();
        cpu_bp = 1'b0;
        check("bp_set_wins", du_if.du_stall_o, 1);
        du_if.du_stall_i = 1'b1;
        tick();
        du_if.du_stall_i = 1'b0;
        tick();
        check("bp_clr2", du_if.du_stall_o, 0);

        // Reset two cycles into REQ
        du_if.du_stall_i = 1'b1;
        du_if.du_stb_i   = 1'b1;
        du_if.du_adr_i   = 16'h0030;
        du_if.du_we_i    = 1'b0;
        tick();
        tick();
        tick();
        check("mid_req_up", spr_req, 1);
        rst            = 1'b1;
        du_if.du_stb_i = 1'b0;
        tick();
        check("mid_rst_req", spr_req,        0);
        check("mid_rst_ack", du_if.du_ack_o, 0);
        rst = 1'b0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (du_if.du_ack_o) acks++;
        end
        check("mid_rst_no_ack", acks, 0);

        // Next access after reset completes normally
        du_if.du_stb_i = 1'b1;
        du_if.du_adr_i = 16'h0040;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (spr_req) begin
                seen = 1'b1;
                break;
            end
        end
        check("post_rst_req", seen, 1);
        spr_ack   = 1'b1;
        spr_rdata = 32'hA5A5_0F0F;
        tick();
        spr_ack = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (du_if.du_ack_o) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("post_rst_ack", seen,           1);
        check("post_rst_err", du_if.du_err_o, 0);
        check("post_rst_dat", du_if.du_dat_o, 32'hA5A5_0F0F);
        du_if.du_stb_i = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
